ftdi_tx_pattern_gen: RTL and testbench

- AXI4-Stream packet source for the FT60x transmit path.
- Its m_axis output drives the s_axis user transmit interface of ftdi_245fifo_top.
- Generates runtime-configured packets with a deterministic byte pattern, used for host-side throughput and integrity testing in place of the loopback FIFO.
- Sits in the tx_clk domain: one clock, no CDC inside.

---
 rtl/ftdi_tx_pattern_gen.sv | 188 ++++++++++++++++++
 tb/tb_ftdi_tx_pattern_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ftdi_tx_pattern_gen.sv
// AXI4-Stream packet source for the FT60x transmit path: emits runtime-configured
// packets whose byte j of packet p is (p + j) mod 256, for host throughput/integrity tests.
module ftdi_tx_pattern_gen #(
    parameter int S_TDATA_WIDTH = 4,
    parameter int LEN_WIDTH     = 16,
    parameter int CNT_WIDTH     = 32
) (
    input  logic                         tx_clk,
    input  logic                         tx_rstn,
    input  logic                         cfg_start,
    input  logic                         cfg_stop,
    input  logic [LEN_WIDTH-1:0]         cfg_pkt_len,
    input  logic [15:0]                  cfg_pkt_num,
    input  logic [7:0]                   cfg_gap,
    output logic                         m_axis_tvalid,
    input  logic                         m_axis_tready,
    output logic [S_TDATA_WIDTH*8-1:0]   m_axis_tdata,
    output logic [S_TDATA_WIDTH-1:0]     m_axis_tkeep,
    output logic [S_TDATA_WIDTH-1:0]     m_axis_tstrb,
    output logic                         m_axis_tlast,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_WIDTH-1:0]         pkt_sent_cnt
);

    localparam int W = S_TDATA_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP
    } state_t;

    state_t                 r_state,    w_state;
    logic [LEN_WIDTH-1:0]   r_lastBeat, w_lastBeat;
    logic [LEN_WIDTH-1:0]   r_rem,      w_rem;
    logic [LEN_WIDTH-1:0]   r_beat,     w_beat;
    logic [15:0]            r_num,      w_num;
    logic [7:0]             r_gap,      w_gap;
    logic [7:0]             r_gapCnt,   w_gapCnt;
    logic [15:0]            r_p,        w_p;
    logic [CNT_WIDTH-1:0]   r_cnt,      w_cnt;
    logic                   r_stop,     w_stop;
    logic                   r_done,     w_done;

    logic [LEN_WIDTH-1:0]   w_cfgLastBeat;
    logic [LEN_WIDTH-1:0]   w_cfgRem;
    logic [CNT_WIDTH-1:0]   w_cntInc;
    logic [7:0]             w_beatBase;
    logic                   w_valid;
    logic                   w_isLast;
    logic                   w_stopReq;
    logic [W*8-1:0]         w_tdata;
    logic [W-1:0]           w_tkeep;

    // Beat count and last-beat remainder are derived once at start so the run ignores later cfg changes.
    assign w_cfgLastBeat = (cfg_pkt_len - LEN_WIDTH'(1)) / LEN_WIDTH'(W);
    assign w_cfgRem      = cfg_pkt_len % LEN_WIDTH'(W);
    assign w_cntInc      = r_cnt + CNT_WIDTH'(1);
    assign w_beatBase    = 8'(r_beat * LEN_WIDTH'(W));
    assign w_valid       = (r_state == S_SEND);
    assign w_isLast      = w_valid && (r_beat == r_lastBeat);
    assign w_stopReq     = r_stop || cfg_stop;

    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            r_state    <= S_IDLE;
            r_lastBeat <= '0;
            r_rem      <= '0;
            r_beat     <= '0;
            r_num      <= '0;
            r_gap      <= '0;
            r_gapCnt   <= '0;
            r_p        <= '0;
            r_cnt      <= '0;
            r_stop     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_lastBeat <= w_lastBeat;
            r_rem      <= w_rem;
            r_beat     <= w_beat;
            r_num      <= w_num;
            r_gap      <= w_gap;
            r_gapCnt   <= w_gapCnt;
            r_p        <= w_p;
            r_cnt      <= w_cnt;
            r_stop     <= w_stop;
            r_done     <= w_done;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_lastBeat = r_lastBeat;
        w_rem      = r_rem;
        w_beat     = r_beat;
        w_num      = r_num;
        w_gap      = r_gap;
        w_gapCnt   = r_gapCnt;
        w_p        = r_p;
        w_cnt      = r_cnt;
        w_stop     = r_stop;
        w_done     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cfg_start && (cfg_pkt_len != '0)) begin
                    w_state    = S_SEND;
                    w_lastBeat = w_cfgLastBeat;
                    w_rem      = w_cfgRem;
                    w_num      = cfg_pkt_num;
                    w_gap      = cfg_gap;
                    w_beat     = '0;
                    w_p        = '0;
                    w_cnt      = '0;
                    w_stop     = 1'b0;
                end
            end

            S_SEND: begin
                if (cfg_stop) begin
                    w_stop = 1'b1;
                end
                if (m_axis_tready) begin
                    if (r_beat == r_lastBeat) begin
                        w_beat = '0;
                        w_p    = r_p + 16'd1;
                        w_cnt  = w_cntInc;
                        if (w_stopReq || ((r_num != 16'd0) && (w_cntInc == CNT_WIDTH'(r_num)))) begin
                            w_state = S_IDLE;
                            w_done  = 1'b1;
                        end else if (r_gap != 8'd0) begin
                            w_state  = S_GAP;
                            w_gapCnt = r_gap;
                        end
                    end else begin
                        w_beat = r_beat + LEN_WIDTH'(1);
                    end
                end
            end

            S_GAP: begin
                if (cfg_stop) begin
                    w_stop = 1'b1;
                end
                if (r_gapCnt <= 8'd1) begin
                    if (w_stopReq) begin
                        w_state = S_IDLE;
                        w_done  = 1'b1;
                    end else begin
                        w_state = S_SEND;
                    end
                end else begin
                    w_gapCnt = r_gapCnt - 8'd1;
                end
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // Lanes beyond the packet end on the final beat are dropped from keep and zeroed in data.
    always_comb begin
        w_tdata = '0;
        w_tkeep = '0;
        if (w_valid) begin
            for (int k = 0; k < W; k++) begin
                if (!w_isLast || (r_rem == '0) || (LEN_WIDTH'(k) < r_rem)) begin
                    w_tkeep[k]       = 1'b1;
                    w_tdata[k*8 +: 8] = r_p[7:0] + w_beatBase + 8'(k);
                end
            end
        end
    end

    assign m_axis_tvalid = w_valid;
    assign m_axis_tdata  = w_tdata;
    assign m_axis_tkeep  = w_tkeep;
    assign m_axis_tstrb  = w_tkeep;
    assign m_axis_tlast  = w_isLast;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign pkt_sent_cnt  = r_cnt;

endmodule

// File: tb/tb_ftdi_tx_pattern_gen.sv
// Directed self-checking bench for ftdi_tx_pattern_gen with W=4; inputs change and
// outputs are sampled on the falling clock edge.
module tb_ftdi_tx_pattern_gen;

    localparam int W = 4;

    logic        tx_clk = 1'b0;
    logic        tx_rstn = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [15:0] cfg_pkt_len = '0;
    logic [15:0] cfg_pkt_num = '0;
    logic [7:0]  cfg_gap = '0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tkeep;
    logic [3:0]  m_axis_tstrb;
    logic        m_axis_tlast;
    logic        busy;
    logic        done;
    logic [31:0] pkt_sent_cnt;

    int errors = 0;
    int checks = 0;

    ftdi_tx_pattern_gen #(
        .S_TDATA_WIDTH(W),
        .LEN_WIDTH(16),
        .CNT_WIDTH(32)
    ) dut (
        .tx_clk(tx_clk),
        .tx_rstn(tx_rstn),
        .cfg_start(cfg_start),
        .cfg_stop(cfg_stop),
        .cfg_pkt_len(cfg_pkt_len),
        .cfg_pkt_num(cfg_pkt_num),
        .cfg_gap(cfg_gap),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tstrb(m_axis_tstrb),
        .m_axis_tlast(m_axis_tlast),
        .busy(busy),
        .done(done),
        .pkt_sent_cnt(pkt_sent_cnt)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic stop, input logic [15:0] len,
                                 input logic [15:0] num, input logic [7:0] gap, input logic ready);
        cfg_start     = start;
        cfg_stop      = stop;
        cfg_pkt_len   = len;
        cfg_pkt_num   = num;
        cfg_gap       = gap;
        m_axis_tready = ready;
    endtask

    task automatic cycle();
        @(negedge tx_clk);
    endtask

    // Reference pattern: byte j of packet p is (p+j) mod 256, unused lanes zero.
    task automatic expBeat(input int p, input int b, input int len,
                           output logic [31:0] d, output logic [3:0] k, output logic l);
        d = '0;
        k = '0;
        for (int i = 0; i < W; i++) begin
            int j;
            j = b * W + i;
            if (j < len) begin
                d[i*8 +: 8] = 8'((p + j) % 256);
                k[i]        = 1'b1;
            end
        end
        l = (b == ((len + W - 1) / W) - 1);
    endtask

    task automatic checkBeat(input string tag, input logic [31:0] d, input logic [3:0] k, input logic l);
        checkOutput({tag, "_beat"}, {31'd0, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast},
                    {31'd0, 1'b1, d, k, k, l});
    endtask

    task automatic waitDone(input string tag, input int budget);
        int c;
        c = 0;
        while (!done && c < budget) begin
            cycle();
            c++;
        end
        checkOutput({tag, "_done_seen"}, {63'd0, done}, 64'd1);
    endtask

    initial begin
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
        int          beats, pk, bt, low, c;
        logic        seen;

        // Reset state
        cycle();
        checkOutput("rst_outputs", {m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tstrb, m_axis_tlast, busy, done, pkt_sent_cnt},
                    '0);
        cycle();
        tx_rstn = 1'b1;
        cycle();

        // len=10 num=2 gap=0; start+stop together in IDLE, stop must be ignored
        applyStimulus(1'b1, 1'b1, 16'd10, 16'd2, 8'd0, 1'b1);
        cycle();
        applyStimulus(1'b1, 1'b0, 16'd4, 16'd1, 8'd5, 1'b1);
        checkBeat("t1_p0b0", 32'h03020100, 4'hF, 1'b0);
        checkOutput("t1_busy", {63'd0, busy}, 64'd1);
        cycle();
        applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        checkBeat("t1_p0b1", 32'h07060504, 4'hF, 1'b0);
        cycle();
        checkBeat("t1_p0b2", 32'h00000908, 4'h3, 1'b1);
        cycle();
        checkBeat("t1_p1b0", 32'h04030201, 4'hF, 1'b0);
        cycle();
        checkBeat("t1_p1b1", 32'h08070605, 4'hF, 1'b0);
        cycle();
        checkBeat("t1_p1b2", 32'h00000A09, 4'h3, 1'b1);
        cycle();
        checkOutput("t1_end", {m_axis_tvalid, busy, done, pkt_sent_cnt}, {3'b001, 32'd2});
        cycle();
        checkOutput("t1_hold", {m_axis_tvalid, busy, done, pkt_sent_cnt}, {3'b000, 32'd2});

        // len=8 num=1: two full beats
        applyStimulus(1'b1, 1'b0, 16'd8, 16'd1, 8'd0, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 16'd8, 16'd1, 8'd0, 1'b1);
        checkBeat("t2_b0", 32'h03020100, 4'hF, 1'b0);
        cycle();
        checkBeat("t2_b1", 32'h07060504, 4'hF, 1'b1);
        cycle();
        checkOutput("t2_end", {m_axis_tvalid, busy, done, pkt_sent_cnt}, {3'b001, 32'd1});
        cycle();

        // len=1: single one-byte beat
        applyStimulus(1'b1, 1'b0, 16'd1, 16'd1, 8'd0, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 16'd1, 16'd1, 8'd0, 1'b1);
        checkBeat("t3_b0", 32'h00000000, 4'h1, 1'b1);
        cycle();
        checkOutput("t3_end", {m_axis_tvalid, busy, done, pkt_sent_cnt}, {3'b001, 32'd1});
        cycle();

        // len=37 num=5 with random backpressure; model index advances only on handshakes
        applyStimulus(1'b1, 1'b0, 16'd37, 16'd5, 8'd0, 1'b0);
        cycle();
        applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b0);
        beats = 0; pk = 0; bt = 0; c = 0;
        while (!done && c < 1000) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            if (m_axis_tvalid) begin
                expBeat(pk, bt, 37, d, k, l);
                checkBeat("t4_rand", d, k, l);
                if (m_axis_tready) begin
                    beats++;
                    if (l) begin
                        pk++;
                        bt = 0;
                    end else begin
                        bt++;
                    end
                end
            end
            cycle();
            c++;
        end
        checkOutput("t4_done", {63'd0, done}, 64'd1);
        checkOutput("t4_beats", 64'(beats), 64'd50);
        checkOutput("t4_cnt", 64'(pkt_sent_cnt), 64'd5);
        m_axis_tready = 1'b1;
        cycle();

        // gap=3 num=3 len=4: three idle cycles between packets, none after the last
        applyStimulus(1'b1, 1'b0, 16'd4, 16'd3, 8'd3, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        seen = 1'b0; low = 0; pk = 0; c = 0;
        while (!done && c < 100) begin
            if (m_axis_tvalid) begin
                if (seen) checkOutput("t5_gap", 64'(low), 64'd3);
                expBeat(pk, 0, 4, d, k, l);
                checkBeat("t5_pkt", d, k, l);
                pk++;
                low = 0;
                seen = 1'b1;
            end else if (seen) begin
                low++;
            end
            cycle();
            c++;
        end
        checkOutput("t5_done", {63'd0, done}, 64'd1);
        checkOutput("t5_tail", 64'(low), 64'd0);
        checkOutput("t5_cnt", 64'(pkt_sent_cnt), 64'd3);
        cycle();

        // num=0 run, stop pulsed during packet 4 (len=8)
        applyStimulus(1'b1, 1'b0, 16'd8, 16'd0, 8'd0, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        c = 0;
        while (!(pkt_sent_cnt == 32'd4 && m_axis_tvalid && !m_axis_tlast) && c < 100) begin
            cycle();
            c++;
        end
        checkBeat("t6_p4b0", 32'h07060504, 4'hF, 1'b0);
        cfg_stop = 1'b1;
        cycle();
        cfg_stop = 1'b0;
        checkBeat("t6_p4b1", 32'h0B0A0908, 4'hF, 1'b1);
        cycle();
        checkOutput("t6_end", {m_axis_tvalid, busy, done, pkt_sent_cnt}, {3'b001, 32'd5});
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (m_axis_tvalid) seen = 1'b1;
        end
        checkOutput("t6_quiet", {63'd0, seen}, 64'd0);

        // Reset mid-run drops tvalid at once; a len=0 start afterwards does nothing
        applyStimulus(1'b1, 1'b0, 16'd4, 16'd0, 8'd0, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        cycle();
        cycle();
        cycle();
        checkOutput("t7_pre", {62'd0, m_axis_tvalid, busy}, 64'd3);
        #2 tx_rstn = 1'b0;
        #1 checkOutput("t7_rst", {m_axis_tvalid, m_axis_tlast, busy, done, pkt_sent_cnt}, '0);
        cycle();
        tx_rstn = 1'b1;
        applyStimulus(1'b1, 1'b0, 16'd0, 16'd3, 8'd0, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m_axis_tvalid || busy || done) seen = 1'b1;
            cycle();
        end
        checkOutput("t7_len0", {63'd0, seen}, 64'd0);

        // Restart after reset begins again at p=0
        applyStimulus(1'b1, 1'b0, 16'd2, 16'd1, 8'd0, 1'b1);
        cycle();
        applyStimulus(1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 1'b1);
        checkBeat("t8_b0", 32'h00000100, 4'h3, 1'b1);
        waitDone("t8", 10);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
